// File: rtl/dfa_seq_pkg.sv
// Shared types and constants for the DFA sequence driver.
//   state_t          : driver FSM states (IDLE, SHIFT, GAP)
//   DEFAULT_MAX_LEN  : default maximum sequence length in bits
//   CNT_SAT          : saturation value of the mismatch counter
package dfa_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int          DEFAULT_MAX_LEN = 8;
  localparam logic [7:0]  CNT_SAT         = 8'hFF;

endpackage

// File: rtl/dfa_seq_shifter.sv
// Load/shift register with a remaining-bit down-counter. On load it
// left-aligns the word so bit [len-1] leaves first, then emits one bit per
// clock until len bits have gone out.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   load       : latch word/len and present the first bit next cycle
//   word, len  : sequence bits and effective length (1..MAX_LEN)
//   bit_out    : serial bit (holds its last value when idle)
//   bit_valid  : bit_out carries a sequence bit
//   seq_last   : current bit is the last of the sequence
module dfa_seq_shifter #(
  parameter int MAX_LEN = dfa_seq_pkg::DEFAULT_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [MAX_LEN-1:0] word,
  input  logic [LEN_W-1:0]   len,
  output logic               bit_out,
  output logic               bit_valid,
  output logic               seq_last
);

  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] sreg_reg;
  logic [LEN_W-1:0]   cnt_reg;   // bits still to send after the current one
  logic [LEN_W-1:0]   shamt;
  logic [MAX_LEN-1:0] aligned;

  // Left-align so the first bit to send sits in the MSB.
  always_comb begin
    shamt   = MAX_L - len;
    aligned = word << shamt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_reg  <= '0;
      cnt_reg   <= '0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      seq_last  <= 1'b0;
    end else if (load) begin
      bit_out   <= aligned[MAX_LEN-1];
      sreg_reg  <= aligned << 1;
      cnt_reg   <= len - LEN_W'(1);
      bit_valid <= 1'b1;
      seq_last  <= (len == LEN_W'(1));
    end else if (bit_valid) begin
      if (seq_last) begin
        // Sequence finished; bit_out deliberately keeps the final bit.
        bit_valid <= 1'b0;
        seq_last  <= 1'b0;
      end else begin
        bit_out   <= sreg_reg[MAX_LEN-1];
        sreg_reg  <= sreg_reg << 1;
        cnt_reg   <= cnt_reg - LEN_W'(1);
        seq_last  <= (cnt_reg == LEN_W'(1));
      end
    end
  end

endmodule

// File: rtl/dfa_seq_driver.sv
// Stimulus generator for serial-input DFA recognisers. Accepts a word and a
// length through valid/ready, shifts the word out MSB-of-length first, and
// pulses seq_done with the golden "ends with 0" verdict after the last bit.
// Optional macro DFA_SEQ_CHECK_EN enables the on-board checker that compares
// dut_accept against exp_accept; without it mismatch_cnt is constant 0.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   s_valid/s_ready          : request handshake
//   s_word, s_len            : sequence bits / requested length
//   bit_out, bit_valid       : serial stream to the DFA
//   seq_last                 : final bit marker
//   exp_accept, seq_done     : golden verdict and its one-cycle strobe
//   len_err                  : sticky, a request asked for more than MAX_LEN
//   dut_accept, mismatch_cnt : checker input and saturating mismatch count
module dfa_seq_driver #(
  parameter int MAX_LEN = dfa_seq_pkg::DEFAULT_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int GAP     = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [MAX_LEN-1:0] s_word,
  input  logic [LEN_W-1:0]   s_len,
  output logic               bit_out,
  output logic               bit_valid,
  output logic               seq_last,
  output logic               exp_accept,
  output logic               seq_done,
  output logic               len_err,
  input  logic               dut_accept,
  output logic [7:0]         mismatch_cnt
);

  import dfa_seq_pkg::*;

  localparam logic [LEN_W-1:0] MAX_L    = LEN_W'(MAX_LEN);
  // Gap counter is loaded on entry to GAP; the seq_done cycle is the first
  // gap cycle, so it counts GAP-1 down to 0.
  localparam logic [7:0]       GAP_LOAD = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

  state_t           state_reg;
  logic             s_ready_reg;
  logic             seq_done_reg;
  logic             exp_accept_reg;
  logic             len_err_reg;
  logic             word0_reg;    // last bit to be sent decides the verdict
  logic [7:0]       gap_cnt_reg;

  logic             hs;
  logic             len_over;
  logic [LEN_W-1:0] len_eff;
  logic             load;

  always_comb begin
    hs       = s_valid & s_ready_reg;
    len_over = (s_len > MAX_L);
    len_eff  = len_over ? MAX_L : s_len;
    load     = hs & (len_eff != '0);
  end

  dfa_seq_shifter #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .word      (s_word),
    .len       (len_eff),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .seq_last  (seq_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      s_ready_reg    <= 1'b0;
      seq_done_reg   <= 1'b0;
      exp_accept_reg <= 1'b0;
      len_err_reg    <= 1'b0;
      word0_reg      <= 1'b0;
      gap_cnt_reg    <= 8'd0;
    end else begin
      seq_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          s_ready_reg <= 1'b1;
          if (hs) begin
            word0_reg <= s_word[0];
            if (len_over) begin
              len_err_reg <= 1'b1;
            end
            if (len_eff == '0) begin
              // Empty string: no bits, rejected verdict next cycle.
              seq_done_reg   <= 1'b1;
              exp_accept_reg <= 1'b0;
              if (GAP == 0) begin
                state_reg   <= IDLE;
                s_ready_reg <= 1'b1;
              end else begin
                state_reg   <= dfa_seq_pkg::GAP;
                s_ready_reg <= 1'b0;
                gap_cnt_reg <= GAP_LOAD;
              end
            end else begin
              state_reg   <= SHIFT;
              s_ready_reg <= 1'b0;
            end
          end
        end
        SHIFT: begin
          s_ready_reg <= 1'b0;
          if (seq_last) begin
            seq_done_reg   <= 1'b1;
            exp_accept_reg <= ~word0_reg;
            if (GAP == 0) begin
              // Reopen in the seq_done cycle for back-to-back sequences.
              state_reg   <= IDLE;
              s_ready_reg <= 1'b1;
            end else begin
              state_reg   <= dfa_seq_pkg::GAP;
              gap_cnt_reg <= GAP_LOAD;
            end
          end
        end
        dfa_seq_pkg::GAP: begin
          if (gap_cnt_reg == 8'd0) begin
            state_reg   <= IDLE;
            s_ready_reg <= 1'b1;
          end else begin
            s_ready_reg <= 1'b0;
            gap_cnt_reg <= gap_cnt_reg - 8'd1;
          end
        end
        default: begin
          state_reg   <= IDLE;
          s_ready_reg <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready    = s_ready_reg;
  assign seq_done   = seq_done_reg;
  assign exp_accept = exp_accept_reg;
  assign len_err    = len_err_reg;

`ifdef DFA_SEQ_CHECK_EN
  logic       chk_reg;           // seq_done belongs to a non-empty sequence
  logic [7:0] mismatch_cnt_reg;

  // The DFA registers the last bit on the edge that consumes it, so its
  // verdict lines up with seq_done and is sampled at the end of that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_reg          <= 1'b0;
      mismatch_cnt_reg <= 8'd0;
    end else begin
      chk_reg <= seq_last;
      if (seq_done_reg && chk_reg && (dut_accept != exp_accept_reg) &&
          (mismatch_cnt_reg != CNT_SAT)) begin
        mismatch_cnt_reg <= mismatch_cnt_reg + 8'd1;
      end
    end
  end

  assign mismatch_cnt = mismatch_cnt_reg;
`else
  logic unused_dut_accept;
  assign unused_dut_accept = dut_accept;
  assign mismatch_cnt      = 8'd0;
`endif

endmodule
